// File: rtl/multiplier_seq_32bit.sv
// multiplier_seq_32bit: iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU), WIDTH+1 cycle latency
module multiplier_seq_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       mul_opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_multiply
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [1:0] op;
  logic [2*WIDTH-1:0] acc, mcand, product;
  logic [WIDTH-1:0] mplier, mag1, mag2;
  logic [CW-1:0] count;
  logic neg, sign1, sign2;
  always_comb begin
    sign1 = (mul_opcode != 2'b11) & operand1[WIDTH-1];
    sign2 = ~mul_opcode[1] & operand2[WIDTH-1];
    mag1 = sign1 ? -operand1 : operand1;
    mag2 = sign2 ? -operand2 : operand2;
    product = neg ? -acc : acc;
  end
  // busy, result_valid and result_multiply are all registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
      count <= '0;
      busy <= 1'b0;
      result_valid <= 1'b0;
      result_multiply <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: if (start && !flush) begin
          op <= mul_opcode;
          mcand <= {{WIDTH{1'b0}}, mag1};
          mplier <= mag2;
          neg <= sign1 ^ sign2;
          acc <= '0;
          count <= '0;
          busy <= 1'b1;
          state <= CALC;
        end
        CALC: if (flush) begin
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          if (mplier[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          count <= count + 1'b1;
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            result_valid <= 1'b1;
            result_multiply <= (op == 2'b00) ? product[WIDTH-1:0] : product[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_seq_32bit.sv
// tb_multiplier_seq_32bit: scoreboard bench; stimulus pushes expected results, a negedge monitor pops and checks them
module tb_multiplier_seq_32bit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0] mul_opcode = '0;
  logic [31:0] operand1 = '0, operand2 = '0;
  logic busy, result_valid;
  logic [31:0] result_multiply;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct {logic [31:0] r; int c; string n;} exp_t;
  exp_t q[$];
  multiplier_seq_32bit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .mul_opcode(mul_opcode),
    .operand1(operand1), .operand2(operand2), .busy(busy),
    .result_valid(result_valid), .result_multiply(result_multiply)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // monitor: every valid pulse must match the oldest expectation, both in value and in cycle
  always @(negedge clk) begin
    if (result_valid) begin
      if (q.size() == 0) check("unexpected_valid", 64'(result_multiply), 64'hDEAD_0000_0000_0000);
      else begin
        exp_t e;
        e = q.pop_front();
        check(e.n, 64'(result_multiply), 64'(e.r));
        check({e.n, "_latency"}, 64'(cyc), 64'(e.c));
      end
    end
  end
  task automatic issue(input string n, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input bit push, output int e);
    @(negedge clk);
    start = 1'b1; mul_opcode = o; operand1 = a; operand2 = b;
    @(posedge clk); #1;
    e = cyc;
    start = 1'b0; operand1 = 32'h5A5A_5A5A; operand2 = 32'hA5A5_A5A5; mul_opcode = 2'b01;
    if (push) q.push_back('{r: r, c: e + 33, n: n});
  endtask
  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || busy) && k < 80) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask
  task automatic pulse_ctl(input bit f, input bit r);
    flush = f; rst = r;
    @(posedge clk); #1;
    flush = 1'b0; rst = 1'b0;
  endtask
  initial begin
    int e;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(result_valid), 64'd0);
    check("reset_result", 64'(result_multiply), 64'd0);
    issue("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 1'b1, e);
    @(negedge clk);
    check("busy_calc", 64'(busy), 64'd1);
    while (cyc < e + 32) @(negedge clk);
    check("busy_done", 64'(busy), 64'd1);
    @(negedge clk);
    check("busy_valid_cycle", 64'(busy), 64'd0);
    drain();
    issue("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, e); drain();
    issue("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, e); drain();
    issue("mulhsu_ff", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, e); drain();
    issue("mulhu_ff", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, e); drain();
    issue("mulh_m1x2", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, e); drain();
    issue("mulhsu_2x8m", 2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 1'b1, e); drain();
    issue("mul_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b1, e); drain();
    issue("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000_000F, 1'b1, e);
    while (cyc < e + 9) @(negedge clk);
    start = 1'b1; operand1 = 32'd9; operand2 = 32'd9; mul_opcode = 2'b00;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < e + 32) @(negedge clk);
    issue("mulhu_b2b", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b1, e);
    drain();
    issue("flush_calc", 2'b00, 32'd3, 32'd5, 32'h0, 1'b0, e);
    while (cyc < e + 12) @(negedge clk);
    pulse_ctl(1'b1, 1'b0);
    @(negedge clk);
    check("flush_calc_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    issue("flush_done", 2'b00, 32'd3, 32'd5, 32'h0, 1'b0, e);
    while (cyc < e + 32) @(negedge clk);
    pulse_ctl(1'b1, 1'b0);
    @(negedge clk);
    check("flush_done_valid", 64'(result_valid), 64'd0);
    check("flush_done_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_dropped", 64'(busy), 64'd0);
    issue("rst_mid", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, e);
    while (cyc < e + 20) @(negedge clk);
    pulse_ctl(1'b0, 1'b1);
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(result_valid), 64'd0);
    check("rst_mid_result", 64'(result_multiply), 64'd0);
    repeat (40) @(negedge clk);
    issue("mul_ffxff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, e);
    drain();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
